// File: rtl/risc_forwarding_unit.sv
// risc_forwarding_unit
//
// Operand-forwarding block at the decode/execute boundary of the 16-bit
// pipelined RISC core. For each of the two source operands it checks whether
// the execute-stage or memory-stage instruction is about to write that
// register and, if so, supplies the in-flight value and a bypass select.
// Two saturating counters record how many operands were forwarded from each
// stage, for performance observation.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//                             (reset affects the counters only)
//   wbExecute, addressExecute, valueExecute   execute-stage producer
//   wbMemo, addressMemo, valueMemo             memory-stage producer
//   sourceAddress1/2          source-operand register addresses
//   result1/2, ctrl1/2        forwarded value and bypass select per operand
//                             (purely combinational)
//   fwdExCount, fwdMemCount   saturating forward-event counters

module risc_forwarding_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbExecute,
  input  logic [2:0]  addressExecute,
  input  logic [15:0] valueExecute,
  input  logic        wbMemo,
  input  logic [2:0]  addressMemo,
  input  logic [15:0] valueMemo,
  input  logic [2:0]  sourceAddress1,
  input  logic [2:0]  sourceAddress2,
  output logic [15:0] result1,
  output logic        ctrl1,
  output logic [15:0] result2,
  output logic        ctrl2,
  output logic [15:0] fwdExCount,
  output logic [15:0] fwdMemCount
);

  logic [1:0][2:0]  srcAddr;
  logic [1:0]       hitEx;
  logic [1:0]       hitMem;
  logic [1:0]       fromEx;   // operand actually sourced from execute stage
  logic [1:0]       fromMem;  // operand actually sourced from memory stage
  logic [1:0][15:0] fwdValue;
  logic [1:0]       fwdSel;

  assign srcAddr[0] = sourceAddress1;
  assign srcAddr[1] = sourceAddress2;

  // Identical forwarding logic per operand. Execute stage wins over memory
  // stage because it holds the younger (more recent) write to the register.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gOperand
      assign hitEx[gi]    = wbExecute && (addressExecute == srcAddr[gi]);
      assign hitMem[gi]   = wbMemo && (addressMemo == srcAddr[gi]);
      assign fromEx[gi]   = hitEx[gi];
      assign fromMem[gi]  = hitMem[gi] && !hitEx[gi];
      assign fwdSel[gi]   = hitEx[gi] || hitMem[gi];
      assign fwdValue[gi] = hitEx[gi]  ? valueExecute :
                            hitMem[gi] ? valueMemo    : 16'h0000;
    end
  endgenerate

  assign result1 = fwdValue[0];
  assign ctrl1   = fwdSel[0];
  assign result2 = fwdValue[1];
  assign ctrl2   = fwdSel[1];

  // Counter increments are 0..2 per cycle; a 17-bit sum exposes the carry
  // so the counters clamp at 16'hFFFF instead of wrapping.
  logic [1:0]  exInc;
  logic [1:0]  memInc;
  logic [16:0] exSum;
  logic [16:0] memSum;
  logic [15:0] fwdExCountReg;
  logic [15:0] fwdMemCountReg;
  logic [15:0] fwdExCountNext;
  logic [15:0] fwdMemCountNext;

  assign exInc  = {1'b0, fromEx[0]}  + {1'b0, fromEx[1]};
  assign memInc = {1'b0, fromMem[0]} + {1'b0, fromMem[1]};
  assign exSum  = {1'b0, fwdExCountReg}  + {15'b0, exInc};
  assign memSum = {1'b0, fwdMemCountReg} + {15'b0, memInc};

  assign fwdExCountNext  = exSum[16]  ? 16'hFFFF : exSum[15:0];
  assign fwdMemCountNext = memSum[16] ? 16'hFFFF : memSum[15:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      fwdExCountReg  <= 16'h0000;
      fwdMemCountReg <= 16'h0000;
    end else begin
      fwdExCountReg  <= fwdExCountNext;
      fwdMemCountReg <= fwdMemCountNext;
    end
  end

  assign fwdExCount  = fwdExCountReg;
  assign fwdMemCount = fwdMemCountReg;

endmodule

// File: tb/tb_risc_forwarding_unit.sv
// Testbench for risc_forwarding_unit.
// Stimulus is applied 1 time unit after each rising edge; each expected
// response is queued at that moment and a monitor compares on the following
// falling edge.

module tb_risc_forwarding_unit;

  logic        clk;
  logic        rst;
  logic        wbExecute;
  logic [2:0]  addressExecute;
  logic [15:0] valueExecute;
  logic        wbMemo;
  logic [2:0]  addressMemo;
  logic [15:0] valueMemo;
  logic [2:0]  sourceAddress1;
  logic [2:0]  sourceAddress2;
  logic [15:0] result1;
  logic        ctrl1;
  logic [15:0] result2;
  logic        ctrl2;
  logic [15:0] fwdExCount;
  logic [15:0] fwdMemCount;

  risc_forwarding_unit dut (
    .clk            (clk),
    .rst            (rst),
    .wbExecute      (wbExecute),
    .addressExecute (addressExecute),
    .valueExecute   (valueExecute),
    .wbMemo         (wbMemo),
    .addressMemo    (addressMemo),
    .valueMemo      (valueMemo),
    .sourceAddress1 (sourceAddress1),
    .sourceAddress2 (sourceAddress2),
    .result1        (result1),
    .ctrl1          (ctrl1),
    .result2        (result2),
    .ctrl2          (ctrl2),
    .fwdExCount     (fwdExCount),
    .fwdMemCount    (fwdMemCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          isCnt;
    string       name;
    logic [15:0] r1;
    logic        c1;
    logic [15:0] r2;
    logic        c2;
    logic [15:0] exCnt;
    logic [15:0] memCnt;
  } expT;

  expT expQ[$];
  int  total = 0;
  int  bad   = 0;

  task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, req);
    end
  endtask

  // Monitor: drains every queued expectation on the falling edge.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        if (e.isCnt) begin
          check16({e.name, ".exCnt"},  fwdExCount,  e.exCnt);
          check16({e.name, ".memCnt"}, fwdMemCount, e.memCnt);
          $display("cnt  %-12s ex=%h mem=%h", e.name, fwdExCount, fwdMemCount);
        end else begin
          check16({e.name, ".result1"}, result1, e.r1);
          check1 ({e.name, ".ctrl1"},   ctrl1,   e.c1);
          check16({e.name, ".result2"}, result2, e.r2);
          check1 ({e.name, ".ctrl2"},   ctrl2,   e.c2);
          $display("fwd  %-12s r1=%h c1=%b r2=%h c2=%b", e.name, result1, ctrl1, result2, ctrl2);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wbE, input logic [2:0] aE, input logic wbM,
                       input logic [2:0] aM, input logic [2:0] s1, input logic [2:0] s2);
    wbExecute      = wbE;
    addressExecute = aE;
    wbMemo         = wbM;
    addressMemo    = aM;
    sourceAddress1 = s1;
    sourceAddress2 = s2;
  endtask

  task automatic expFwd(input string nm, input logic [15:0] r1, input logic c1,
                        input logic [15:0] r2, input logic c2);
    expT e;
    e.isCnt = 1'b0; e.name = nm;
    e.r1 = r1; e.c1 = c1; e.r2 = r2; e.c2 = c2;
    e.exCnt = '0; e.memCnt = '0;
    expQ.push_back(e);
  endtask

  task automatic expCnt(input string nm, input logic [15:0] ex, input logic [15:0] mem);
    expT e;
    e.isCnt = 1'b1; e.name = nm;
    e.r1 = '0; e.c1 = 1'b0; e.r2 = '0; e.c2 = 1'b0;
    e.exCnt = ex; e.memCnt = mem;
    expQ.push_back(e);
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0);
  endtask

  initial begin
    int waitCycles;
    rst          = 1'b1;
    valueExecute = 16'hFFFF;
    valueMemo    = 16'hF0F0;
    idle();

    // Reset state, and forwarding stays live while reset is asserted.
    step(); step();
    expCnt("reset", 16'd0, 16'd0);
    step();
    drive(1'b1, 3'd1, 1'b1, 3'd1, 3'd1, 3'd1);
    expFwd("fwdInReset", 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    step();
    expCnt("hitInReset", 16'd0, 16'd0);
    rst = 1'b0;

    // Priority stimulus held for three counting edges: 2 ex hits per edge.
    step(); step(); step();
    idle();
    expCnt("threeCycles", 16'd6, 16'd0);

    // Forwarding vectors, each held for exactly one edge.
    step();
    drive(1'b1, 3'd5, 1'b1, 3'd7, 3'd7, 3'd7);          // mem +2
    expFwd("memFwd", 16'hF0F0, 1'b1, 16'hF0F0, 1'b1);
    step();
    drive(1'b1, 3'd5, 1'b1, 3'd7, 3'd5, 3'd7);          // ex +1, mem +1
    expFwd("mixed57", 16'hFFFF, 1'b1, 16'hF0F0, 1'b1);
    step();
    drive(1'b1, 3'd5, 1'b1, 3'd7, 3'd1, 3'd5);          // ex +1
    expFwd("mixed15", 16'h0000, 1'b0, 16'hFFFF, 1'b1);
    step();
    drive(1'b1, 3'd1, 1'b1, 3'd1, 3'd1, 3'd1);          // ex +2
    expFwd("priority", 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    step();
    drive(1'b0, 3'd1, 1'b1, 3'd3, 3'd1, 3'd0);          // none
    expFwd("wbOffSrc0", 16'h0000, 1'b0, 16'h0000, 1'b0);
    step();
    drive(1'b0, 3'd1, 1'b1, 3'd3, 3'd1, 3'd3);          // mem +1
    expFwd("wbOffSrc3", 16'h0000, 1'b0, 16'hF0F0, 1'b1);
    step();
    drive(1'b1, 3'd0, 1'b1, 3'd7, 3'd0, 3'd7);          // ex +1, mem +1
    expFwd("reg0", 16'hFFFF, 1'b1, 16'hF0F0, 1'b1);
    step();
    drive(1'b1, 3'd2, 1'b0, 3'd4, 3'd4, 3'd4);          // wbMemo off: none
    expFwd("memWbOff", 16'h0000, 1'b0, 16'h0000, 1'b0);
    step();
    idle();
    // ex: 6+1+1+2+1 = 11, mem: 2+1+1+1 = 5
    expCnt("afterVectors", 16'd11, 16'd5);

    // Single reset edge clears both counters.
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    expCnt("resetPulse", 16'd0, 16'd0);

    // Execute counter saturation: +2 per edge from zero.
    drive(1'b1, 3'd1, 1'b1, 3'd1, 3'd1, 3'd1);
    repeat (32767) step();
    expCnt("exNearSat", 16'hFFFE, 16'd0);
    step();
    expCnt("exSat", 16'hFFFF, 16'd0);
    repeat (5) step();
    expCnt("exHold", 16'hFFFF, 16'd0);

    // Memory counter saturation: +2 per edge, execute counter stays pinned.
    drive(1'b1, 3'd5, 1'b1, 3'd7, 3'd7, 3'd7);
    repeat (32767) step();
    expCnt("memNearSat", 16'hFFFF, 16'hFFFE);
    step();
    expCnt("memSat", 16'hFFFF, 16'hFFFF);
    repeat (5) step();
    expCnt("memHold", 16'hFFFF, 16'hFFFF);

    // Reset from saturation, with hits present on the reset edge.
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    expCnt("resetFromSat", 16'd0, 16'd0);

    // Let the monitor drain, with a bounded wait.
    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 20) begin
      @(posedge clk);
      waitCycles++;
    end
    total++;
    if (expQ.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", expQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
